// File: rtl/syndrome_gen_param.sv
// Reed-Solomon syndrome generator over GF(2^M). Horner accumulators evaluate r(alpha^(FCR+j)),
// and the finished syndromes are handed to a double-buffered output bank that drains one per beat.
module syndrome_gen_param #(
    parameter int           M         = 4,
    parameter int           N         = 15,
    parameter int           TWO_T     = 4,
    parameter logic [M:0]   PRIM_POLY = 5'b10011,
    parameter int           FCR       = 1,
    localparam int          IDX_W     = (TWO_T > 1) ? $clog2(TWO_T) : 1,
    localparam int          CNT_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             in_valid_i,
    input  logic             in_sop_i,
    input  logic [M-1:0]     in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [M-1:0]     out_data_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             out_last_o,
    output logic             err_free_o,
    output logic             frame_err_o,
    output logic             state_o
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TWO_T - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] v);
        logic [M:0] s;
        s = {v, 1'b0};
        if (s[M]) s = s ^ PRIM_POLY;
        return s[M-1:0];
    endfunction

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        r = '0;
        for (int i = M - 1; i >= 0; i--) begin
            r = gf_xtime(r);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [M-1:0] alpha_pow(input int k);
        logic [M-1:0] p;
        p = M'(1);
        for (int i = 0; i < k; i++) p = gf_xtime(p);
        return p;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [M-1:0]      acc_q   [TWO_T];
    logic [M-1:0]      acc_d   [TWO_T];
    logic [M-1:0]      bank_q  [TWO_T];
    logic [M-1:0]      bank_d  [TWO_T];
    logic [M-1:0]      mul_out [TWO_T];
    logic              out_valid_q, out_valid_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              err_free_q, err_free_d;
    logic              frame_err_q, frame_err_d;

    // Constant multipliers: the multiplicand is elaborated, so each collapses to an XOR network.
    for (genvar j = 0; j < TWO_T; j++) begin : g_mul
        localparam logic [M-1:0] ROOT = alpha_pow(FCR + j);
        assign mul_out[j] = gf_mul(acc_q[j], ROOT);
    end

    logic             accept;
    logic             bank_free;
    logic             load_en;
    logic             load_from_acc_q;
    logic [CNT_W-1:0] pos;
    logic [M-1:0]     any_nz;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        acc_d           = acc_q;
        bank_d          = bank_q;
        out_valid_d     = out_valid_q;
        out_idx_d       = out_idx_q;
        err_free_d      = err_free_q;
        frame_err_d     = 1'b0;
        load_en         = 1'b0;
        load_from_acc_q = 1'b0;
        pos             = '0;
        any_nz          = '0;

        in_ready_o = (state_q == ACCUM);
        accept     = in_valid_i & in_ready_o;
        bank_free  = ~out_valid_q | (out_ready_i & (out_idx_q == LAST_IDX));

        if (out_valid_q && out_ready_i) begin
            if (out_idx_q == LAST_IDX) begin
                out_valid_d = 1'b0;
                out_idx_d   = '0;
            end else begin
                out_idx_d = out_idx_q + IDX_W'(1);
            end
        end

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (cnt_q == '0 && !in_sop_i) begin
                        frame_err_d = 1'b1;
                    end else begin
                        // SOP mid-codeword discards the partial sums and restarts at degree N-1.
                        if (in_sop_i && cnt_q != '0) frame_err_d = 1'b1;
                        pos = in_sop_i ? '0 : cnt_q;
                        for (int j = 0; j < TWO_T; j++)
                            acc_d[j] = (in_sop_i ? '0 : mul_out[j]) ^ in_data_i;
                        if (pos == LAST_CNT) begin
                            cnt_d = '0;
                            if (bank_free) load_en = 1'b1;
                            else           state_d = HOLD;
                        end else begin
                            cnt_d = pos + CNT_W'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (bank_free) begin
                    load_en         = 1'b1;
                    load_from_acc_q = 1'b1;
                    state_d         = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase

        if (load_en) begin
            for (int j = 0; j < TWO_T; j++) begin
                bank_d[j] = load_from_acc_q ? acc_q[j] : acc_d[j];
                any_nz    = any_nz | bank_d[j];
            end
            out_valid_d = 1'b1;
            out_idx_d   = '0;
            err_free_d  = (any_nz == '0);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            err_free_q  <= 1'b0;
            frame_err_q <= 1'b0;
            for (int j = 0; j < TWO_T; j++) begin
                acc_q[j]  <= '0;
                bank_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            err_free_q  <= err_free_d;
            frame_err_q <= frame_err_d;
            for (int j = 0; j < TWO_T; j++) begin
                acc_q[j]  <= acc_d[j];
                bank_q[j] <= bank_d[j];
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = bank_q[out_idx_q];
    assign out_idx_o   = out_idx_q;
    assign out_last_o  = out_valid_q & (out_idx_q == LAST_IDX);
    assign err_free_o  = err_free_q;
    assign frame_err_o = frame_err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_syndrome_gen_param.sv
// Bench for syndrome_gen_param at default parameters (GF(16), RS(15,11), FCR=1).
// Expected syndromes are hand-computed from the alpha power table of x^4+x+1.
module tb_syndrome_gen_param;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_sop;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_idx;
    logic       out_last;
    logic       err_free;
    logic       frame_err;
    logic       state_dbg;

    syndrome_gen_param dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .in_valid_i  (in_valid),
        .in_sop_i    (in_sop),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_idx_o   (out_idx),
        .out_last_o  (out_last),
        .err_free_o  (err_free),
        .frame_err_o (frame_err),
        .state_o     (state_dbg)
    );

    // Codewords: symbol 0 (degree 14, sent with SOP) is the top nibble.
    localparam logic [59:0] CW_ZERO  = 60'h0;
    localparam logic [59:0] CW_LAST1 = 60'h000000000000001;
    localparam logic [59:0] CW_FIRST1 = 60'h100000000000000;
    localparam logic [59:0] CW_DEG1_2 = 60'h000000000000020;
    localparam logic [59:0] CW_BOTH   = 60'h100000000000001;

    int tests  = 0;
    int fails  = 0;
    int fe_cnt = 0;

    // {err_free, last, idx, data}
    logic [7:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_exp(input logic [15:0] syn);
        logic ef;
        ef = (syn == 16'h0);
        for (int j = 0; j < 4; j++)
            exp_q.push_back({ef, (j == 3), 2'(j), syn[15 - 4*j -: 4]});
    endtask

    task automatic send_sym(input logic sop, input logic [3:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_sop   = sop;
        in_data  = d;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic send_cw(input logic [59:0] cw, input logic [15:0] syn);
        push_exp(syn);
        for (int i = 0; i < 15; i++)
            send_sym(i == 0, cw[59 - 4*i -: 4]);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_complete", exp_q.size(), 0);
    endtask

    // Monitor: pops on every handshake and checks stability of a stalled beat.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_beat;
    always @(negedge clk) begin
        logic [7:0] got;
        logic [7:0] e;
        got = {err_free, out_last, out_idx, out_data};
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (frame_err) fe_cnt++;
            if (prev_stall) begin
                tests++;
                if (!out_valid || got !== prev_beat) begin
                    fails++;
                    $display("FAIL stall_stable: got v=%0b beat=%0h required v=1 beat=%0h",
                             out_valid, got, prev_beat);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got %0h required none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        fails++;
                        $display("FAIL beat: got ef/last/idx/data=%0h required %0h", got, e);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = got;
        end
    end

    initial begin
        int fe_base;
        int t;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {in_ready, out_valid, out_data, out_idx, out_last, err_free, frame_err},
              {1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // All-zero codeword, with first-beat latency check.
        send_cw(CW_ZERO, 16'h0000);
        check("latency_first_beat", {out_valid, out_idx}, {1'b1, 2'd0});
        wait_drain();

        send_cw(CW_LAST1, 16'h1111);
        wait_drain();
        send_cw(CW_FIRST1, 16'h9DFE);
        wait_drain();
        send_cw(CW_DEG1_2, 16'h4836);
        wait_drain();
        send_cw(CW_BOTH, 16'h8CEF);
        wait_drain();

        // Back-to-back under backpressure: second codeword must wait in HOLD.
        out_ready = 1'b0;
        send_cw(CW_FIRST1, 16'h9DFE);
        send_cw(CW_ZERO, 16'h0000);
        check("hold_in_ready_low", {in_ready, state_dbg}, {1'b0, 1'b1});
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        check("hold_released", {in_ready, state_dbg}, {1'b1, 1'b0});

        // SOP re-asserted at symbol 7 aborts the partial codeword.
        fe_base = fe_cnt;
        send_sym(1'b1, 4'h3);
        for (int i = 1; i < 7; i++) send_sym(1'b0, 4'(i));
        send_cw(CW_FIRST1, 16'h9DFE);
        wait_drain();
        check("frame_err_sop_abort", fe_cnt - fe_base, 1);

        // Symbol without SOP at cnt=0 is dropped.
        fe_base = fe_cnt;
        send_sym(1'b0, 4'h5);
        send_cw(CW_LAST1, 16'h1111);
        wait_drain();
        check("frame_err_drop", fe_cnt - fe_base, 1);

        // SOP on what would be the last symbol is abort plus restart, not completion.
        fe_base = fe_cnt;
        send_sym(1'b1, 4'h7);
        for (int i = 1; i < 14; i++) send_sym(1'b0, 4'h2);
        send_cw(CW_DEG1_2, 16'h4836);
        wait_drain();
        check("frame_err_sop_last", fe_cnt - fe_base, 1);

        // Async reset during beat 2 of the drain.
        send_cw(CW_BOTH, 16'h8CEF);
        t = 0;
        while (!(out_valid && out_idx == 2'd2) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("reached_beat2", {out_valid, out_idx}, {1'b1, 2'd2});
        reset_n = 1'b0;
        #1;
        check("reset_async_valid", {out_valid, out_idx, in_ready}, {1'b0, 2'd0, 1'b1});
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("no_beats_after_reset", out_valid, 1'b0);
        send_cw(CW_FIRST1, 16'h9DFE);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
